// File: rtl/sseg_serial_driver_pkg.sv
// sseg_serial_driver_pkg
// Shared constants and types for the serial seven-segment driver:
//   SEG_LUT    - active-low {dp,g,f,e,d,c,b,a} patterns for hex 0..F (dp off)
//   SEG_BLANK  - pattern with every segment and the DP dark
//   FRAME_W    - default frame width (8 digits x 8 bits)
//   state_e    - shift FSM states
package sseg_serial_driver_pkg;

  localparam int NUM_DIGITS_DEF = 8;
  localparam int FRAME_W        = 8 * NUM_DIGITS_DEF;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

endpackage

// File: rtl/sseg_serial_driver_if.sv
// sseg_serial_driver_if
// Bundles the display-control inputs and the serial chain outputs.
//   Start, flash, Hexs, point, LES         : control side -> driver
//   seg_clk, seg_clrn, seg_sout, SEG_PEN   : driver -> shift-register chain
// Modports: master (controller / bench), slave (the driver).
interface sseg_serial_driver_if #(
  parameter int NUM_DIGITS = 8
);

  logic                      Start;
  logic                      flash;
  logic [4*NUM_DIGITS-1:0]   Hexs;
  logic [NUM_DIGITS-1:0]     point;
  logic [NUM_DIGITS-1:0]     LES;
  logic                      seg_clk;
  logic                      seg_clrn;
  logic                      seg_sout;
  logic                      SEG_PEN;

  modport master (
    output Start, flash, Hexs, point, LES,
    input  seg_clk, seg_clrn, seg_sout, SEG_PEN
  );

  modport slave (
    input  Start, flash, Hexs, point, LES,
    output seg_clk, seg_clrn, seg_sout, SEG_PEN
  );

endinterface

// File: rtl/sseg_serial_driver_hex_to_seg7.sv
// hex_to_seg7
// Converts one hex nibble into an active-low segment byte {dp,g,f,e,d,c,b,a}.
//   nibble_i : digit value 0..F
//   dp_i     : 1 lights the decimal point
//   blank_i  : 1 forces the whole digit (DP included) dark
//   seg_o    : resulting segment byte
module hex_to_seg7
  import sseg_serial_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Blanking has priority over both the decoded value and the DP.
  always_comb begin
    seg_o = SEG_LUT[nibble_i];
    if (dp_i) begin
      seg_o[7] = 1'b0;
    end
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/sseg_serial_driver.sv
// sseg_serial_driver
// Decodes NUM_DIGITS hex digits into a segment frame and, on each rising
// edge of bus.Start, shifts it MSB first into a 74HC164-style chain.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : slave modport carrying Start/flash/Hexs/point/LES in and
//          seg_clk/seg_clrn/seg_sout/SEG_PEN out
module sseg_serial_driver
  import sseg_serial_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = FRAME_W / 8,
  parameter int HALF_PERIOD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sseg_serial_driver_if.slave  bus
);

  localparam int FW = 8 * NUM_DIGITS;
  localparam int BW = $clog2(FW);
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);

  logic [FW-1:0] frame;

  state_e        state_q, state_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [BW-1:0] bitCnt_q, bitCnt_d;
  logic [PW-1:0] phaseCnt_q, phaseCnt_d;
  logic          phaseHigh_q, phaseHigh_d;
  logic          segClk_q, segClk_d;
  logic          segPen_q, segPen_d;
  logic          segClrn_q;
  logic          startDly_q;

  logic startEdge;
  logic phaseDone;
  logic lastBit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      hex_to_seg7 u_seg (
        .nibble_i (bus.Hexs[4*gi +: 4]),
        .dp_i     (bus.point[gi]),
        .blank_i  (bus.LES[gi] & bus.flash),
        .seg_o    (frame[8*gi +: 8])
      );
    end
  endgenerate

  assign startEdge = bus.Start & ~startDly_q;
  assign phaseDone = (phaseCnt_q == PH_LAST);
  assign lastBit   = (bitCnt_q == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      phaseCnt_q  <= '0;
      phaseHigh_q <= 1'b0;
      segClk_q    <= 1'b0;
      segPen_q    <= 1'b0;
      segClrn_q   <= 1'b0;
      startDly_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      phaseCnt_q  <= phaseCnt_d;
      phaseHigh_q <= phaseHigh_d;
      segClk_q    <= segClk_d;
      segPen_q    <= segPen_d;
      segClrn_q   <= 1'b1;
      startDly_q  <= bus.Start;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (startEdge) state_d = ST_SHIFT;
      ST_SHIFT: if (lastBit && phaseHigh_q && phaseDone) state_d = ST_IDLE;
    endcase
  end

  // The serial data is the shift register MSB, so loading the frame puts
  // bit 63 on seg_sout for the first low phase; each high->low transition
  // shifts the next bit up. Clearing the register at the end drives sout low.
  always_comb begin
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    phaseCnt_d  = phaseCnt_q;
    phaseHigh_d = phaseHigh_q;
    segClk_d    = segClk_q;
    segPen_d    = segPen_q;
    unique case (state_q)
      ST_IDLE: begin
        segClk_d = 1'b0;
        if (startEdge) begin
          shift_d     = frame;
          bitCnt_d    = '0;
          phaseCnt_d  = '0;
          phaseHigh_d = 1'b0;
          segPen_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!phaseDone) begin
          phaseCnt_d = phaseCnt_q + 1'b1;
        end else begin
          phaseCnt_d = '0;
          if (!phaseHigh_q) begin
            phaseHigh_d = 1'b1;
            segClk_d    = 1'b1;
          end else if (lastBit) begin
            phaseHigh_d = 1'b0;
            segClk_d    = 1'b0;
            shift_d     = '0;
            segPen_d    = 1'b1;
          end else begin
            phaseHigh_d = 1'b0;
            segClk_d    = 1'b0;
            shift_d     = {shift_q[FW-2:0], 1'b0};
            bitCnt_d    = bitCnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.seg_clk  = segClk_q;
  assign bus.seg_clrn = segClrn_q;
  assign bus.seg_sout = shift_q[FW-1];
  assign bus.SEG_PEN  = segPen_q;

endmodule

// File: tb/tb_sseg_serial_driver.sv
module tb_sseg_serial_driver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sseg_serial_driver_if #(.NUM_DIGITS(8)) bus ();

  sseg_serial_driver #(
    .NUM_DIGITS  (8),
    .HALF_PERIOD (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          capCount = 0;
  int          penRises = 0;
  logic [63:0] capWord  = '0;

  // Model of the external chain: sample serial data on each shift-clock rise.
  always @(posedge bus.seg_clk) begin
    capWord  = {capWord[62:0], bus.seg_sout};
    capCount = capCount + 1;
  end

  always @(posedge bus.SEG_PEN) begin
    penRises = penRises + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] hexs, input logic [7:0] pt,
                               input logic [7:0] les, input logic fl);
    bus.Hexs  = hexs;
    bus.point = pt;
    bus.LES   = les;
    bus.flash = fl;
  endtask

  // Sends one frame and checks timing, bit count, content and idle behaviour.
  // retrigAt / changeAt give the cycle (0 = never) of a Start re-pulse or an
  // input change while the frame is in flight.
  task automatic runFrame(input string tag, input logic [63:0] expFrame,
                          input int retrigAt, input int changeAt,
                          input logic [31:0] newHexs);
    int   startCap;
    int   startPen;
    int   n;
    logic done;
    startCap = capCount;
    startPen = penRises;
    done     = 1'b0;
    n        = 0;
    @(negedge clk);
    bus.Start = 1'b1;
    for (int i = 1; i <= 400 && !done; i++) begin
      @(negedge clk);
      n = i;
      if (i == 1) checkOutput({tag, "_pen_low"}, 64'(bus.SEG_PEN), 64'd0);
      if (i == 2) bus.Start = 1'b0;
      if (i == retrigAt) bus.Start = 1'b1;
      if (i == retrigAt + 2) bus.Start = 1'b0;
      if (i == changeAt) bus.Hexs = newHexs;
      if (bus.SEG_PEN === 1'b1) done = 1'b1;
    end
    checkOutput({tag, "_cycles"}, 64'(n), 64'd129);
    checkOutput({tag, "_edges"}, 64'(capCount - startCap), 64'd64);
    checkOutput({tag, "_frame"}, capWord, expFrame);
    checkOutput({tag, "_clk_end"}, 64'(bus.seg_clk), 64'd0);
    checkOutput({tag, "_sout_end"}, 64'(bus.seg_sout), 64'd0);
    checkOutput({tag, "_pen_rises"}, 64'(penRises - startPen), 64'd1);
    repeat (20) @(negedge clk);
    checkOutput({tag, "_idle_edges"}, 64'(capCount - startCap), 64'd64);
    checkOutput({tag, "_idle_clk"}, 64'(bus.seg_clk), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.Start = 1'b0;
    applyStimulus(32'h0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_outs",
                64'({bus.seg_clk, bus.seg_sout, bus.seg_clrn, bus.SEG_PEN}), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("clrn_at_release", 64'(bus.seg_clrn), 64'd0);
    @(negedge clk);
    checkOutput("clrn_after_release", 64'(bus.seg_clrn), 64'd1);

    applyStimulus(32'h0000_0003, 8'b0100_0001, 8'h00, 1'b0);
    runFrame("dp_frame", 64'hC040_C0C0_C0C0_C030, 0, 0, 32'h0);

    applyStimulus(32'h89AB_CDEF, 8'h00, 8'h00, 1'b0);
    runFrame("hex_frame", 64'h8090_8883_C6A1_868E, 0, 0, 32'h0);

    applyStimulus(32'h89AB_CDEF, 8'h00, 8'h01, 1'b1);
    runFrame("blank_on", 64'h8090_8883_C6A1_86FF, 0, 0, 32'h0);

    applyStimulus(32'h89AB_CDEF, 8'h00, 8'h01, 1'b0);
    runFrame("blank_off", 64'h8090_8883_C6A1_868E, 0, 0, 32'h0);

    runFrame("retrigger", 64'h8090_8883_C6A1_868E, 40, 0, 32'h0);

    applyStimulus(32'h89AB_CDEF, 8'h00, 8'h00, 1'b0);
    runFrame("mid_change", 64'h8090_8883_C6A1_868E, 0, 50, 32'h1234_5678);
    runFrame("new_value", 64'hF9A4_B099_9282_F880, 0, 0, 32'h0);

    // Abort a frame part-way with an asynchronous reset.
    @(negedge clk);
    bus.Start = 1'b1;
    repeat (31) @(negedge clk);
    bus.Start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_outs",
                64'({bus.seg_clk, bus.seg_sout, bus.seg_clrn, bus.SEG_PEN}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_clrn_release", 64'(bus.seg_clrn), 64'd0);
    @(negedge clk);
    checkOutput("abort_clrn_after", 64'(bus.seg_clrn), 64'd1);
    checkOutput("abort_pen", 64'(bus.SEG_PEN), 64'd0);

    runFrame("recovery", 64'hF9A4_B099_9282_F880, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
